// File: rtl/bus_trace_buffer_if.sv
// Bus-side and stream-side signals of the bus trace buffer.
// The capture inputs and the byte-stream handshake are grouped here.
interface bus_trace_buffer_if;
  logic [15:0] addr;
  logic [7:0]  data;
  logic        rd;
  logic        wr;
  logic        cs;
  logic        halt;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        dumping;
  logic        overflow;

  modport slave (
    input  addr, data, rd, wr, cs, halt, out_ready,
    output out_data, out_valid, dumping, overflow
  );

  modport master (
    output addr, data, rd, wr, cs, halt, out_ready,
    input  out_data, out_valid, dumping, overflow
  );
endinterface

// File: rtl/bus_trace_buffer.sv
// Ring buffer of CPU bus strobe events.
// On a rising halt it replays the history oldest-first as 4-byte records over valid/ready.
module bus_trace_buffer #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              reset,
  bus_trace_buffer_if.slave bus
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          overflow_q, overflow_d;
  logic          rd_q, wr_q, halt_q;
  logic [25:0]   mem [DEPTH];

  logic          capture, halt_rise, cap_we;
  logic [PW-1:0] rptr_nx;

  function automatic logic [7:0] pick(input logic [25:0] e, input logic [1:0] i);
    case (i)
      2'd0:    pick = {6'b111000, e[25:24]};
      2'd1:    pick = e[23:16];
      2'd2:    pick = e[15:8];
      default: pick = e[7:0];
    endcase
  endfunction

  assign capture   = bus.cs & ((bus.rd & ~rd_q) | (bus.wr & ~wr_q));
  assign halt_rise = bus.halt & ~halt_q;
  assign cap_we    = (state_q == IDLE) && capture;
  assign rptr_nx   = rptr_q + PW'(1);

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;
    case (state_q)
      IDLE: begin
        if (capture) begin
          wptr_d = wptr_q + PW'(1);
          if (count_q == CW'(DEPTH)) begin
            rptr_d     = rptr_nx;
            overflow_d = 1'b1;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
        // Decide on the post-capture count so a same-cycle event is dumped too.
        if (halt_rise) state_d = (count_d != '0) ? SEND : DONE;
      end
      SEND: begin
        if (!out_valid_q) begin
          out_data_d  = pick(mem[rptr_q], 2'd0);
          out_valid_d = 1'b1;
          idx_d       = 2'd0;
        end else if (bus.out_ready) begin
          if (idx_q == 2'd3) begin
            rptr_d  = rptr_nx;
            count_d = count_q - CW'(1);
            idx_d   = 2'd0;
            if (count_q == CW'(1)) begin
              state_d     = DONE;
              out_valid_d = 1'b0;
            end else begin
              // Preload the next record's flags byte so entry boundaries have no bubble.
              out_data_d = pick(mem[rptr_nx], 2'd0);
            end
          end else begin
            idx_d      = idx_q + 2'd1;
            out_data_d = pick(mem[rptr_q], idx_q + 2'd1);
          end
        end
      end
      DONE: begin
        if (!bus.halt) begin
          state_d    = IDLE;
          overflow_d = 1'b0;
          wptr_d     = '0;
          rptr_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      halt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      rd_q        <= bus.rd;
      wr_q        <= bus.wr;
      halt_q      <= bus.halt;
    end
  end

  always_ff @(posedge clk) begin
    if (cap_we) mem[wptr_q] <= {bus.wr, bus.rd, bus.addr, bus.data};
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.dumping   = (state_q == SEND);
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_bus_trace_buffer.sv
// Scoreboard bench for bus_trace_buffer: a ring model feeds an expected byte queue
// that is compared against every accepted stream byte.
module tb_bus_trace_buffer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_trace_buffer_if bus ();
  bus_trace_buffer #(.DEPTH_LOG2(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  int          checks = 0;
  int          errors = 0;
  logic [25:0] model_q[$];
  logic [7:0]  exp_q[$];
  logic        exp_ovf = 1'b0;

  task automatic bus_event(input logic [15:0] a, input logic [7:0] d,
                           input logic r, input logic w, input logic c);
    @(negedge clk);
    bus.addr = a; bus.data = d; bus.rd = r; bus.wr = w; bus.cs = c;
    if (c && (r || w)) begin
      if (model_q.size() == 16) begin
        void'(model_q.pop_front());
        exp_ovf = 1'b1;
      end
      model_q.push_back({w, r, a, d});
    end
    @(negedge clk);
    bus.rd = 1'b0; bus.wr = 1'b0; bus.cs = 1'b0;
  endtask

  task automatic start_halt();
    logic [25:0] e;
    bit          nonempty;
    while (model_q.size() != 0) begin
      e = model_q.pop_front();
      exp_q.push_back({6'b111000, e[25:24]});
      exp_q.push_back(e[23:16]);
      exp_q.push_back(e[15:8]);
      exp_q.push_back(e[7:0]);
    end
    nonempty = (exp_q.size() != 0);
    @(negedge clk);
    bus.halt = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (bus.dumping !== nonempty) begin
      errors++;
      $display("FAIL halt_latency_dumping: got %b want %b", bus.dumping, nonempty);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_latency_valid: got %b want 0", bus.out_valid);
    end
  endtask

  // mode 0: ready held high; mode 1: ready toggles every 3 cycles. stop_after<0 drains fully.
  task automatic drain(input int mode, input int stop_after);
    int   popped = 0;
    bit   last = 1'b0, prev_stall = 1'b0, done = 1'b0;
    logic [7:0] prev_data = '0, want;
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      @(negedge clk);
      bus.out_ready = (mode == 0) ? 1'b1 : (((cyc / 3) % 2) == 0);
      #1;
      if (last) begin
        checks++;
        if (bus.out_valid !== 1'b0 || bus.dumping !== 1'b0) begin
          errors++;
          $display("FAIL dump_end: valid=%b dumping=%b want 0/0", bus.out_valid, bus.dumping);
        end
        checks++;
        if (bus.overflow !== exp_ovf) begin
          errors++;
          $display("FAIL overflow_at_done: got %b want %b", bus.overflow, exp_ovf);
        end
        done = 1'b1;
      end else begin
        if (prev_stall) begin
          checks++;
          if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data) begin
            errors++;
            $display("FAIL stall_stable: valid=%b data=%h want 1/%h", bus.out_valid, bus.out_data, prev_data);
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        if (bus.out_valid && bus.out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_byte: got %h want none", bus.out_data);
          end else begin
            want = exp_q.pop_front();
            if (bus.out_data !== want || bus.dumping !== 1'b1) begin
              errors++;
              $display("FAIL byte_%0d: data=%h dumping=%b want %h/1", popped, bus.out_data, bus.dumping, want);
            end
          end
          popped++;
          if (stop_after >= 0 && popped == stop_after) done = 1'b1;
          else if (exp_q.size() == 0) last = 1'b1;
        end
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d bytes left want 0", exp_q.size());
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic end_halt();
    @(negedge clk);
    bus.halt = 1'b0;
    @(negedge clk); #1;
    exp_ovf = 1'b0;
    checks++;
    if (bus.overflow !== 1'b0 || bus.out_valid !== 1'b0 || bus.dumping !== 1'b0) begin
      errors++;
      $display("FAIL after_halt_idle: ovf=%b valid=%b dumping=%b want 0/0/0",
               bus.overflow, bus.out_valid, bus.dumping);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.addr = '0; bus.data = '0; bus.rd = 1'b0; bus.wr = 1'b0; bus.cs = 1'b0;
    bus.halt = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.out_data !== 8'h00 || bus.out_valid !== 1'b0 || bus.dumping !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: data=%h valid=%b dumping=%b ovf=%b want 00/0/0/0",
               bus.out_data, bus.out_valid, bus.dumping, bus.overflow);
    end
  endtask

  task automatic test_basic();
    bus_event(16'hFF40, 8'h91, 1'b0, 1'b1, 1'b1);
    bus_event(16'hC000, 8'h12, 1'b0, 1'b1, 1'b1);
    bus_event(16'h0150, 8'h3E, 1'b1, 1'b0, 1'b1);
    start_halt();
    drain(0, -1);
    end_halt();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 20; i++) bus_event(16'(i), 8'(i), 1'b0, 1'b1, 1'b1);
    #1;
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: got %b want 1", bus.overflow);
    end
    start_halt();
    drain(0, -1);
    end_halt();
  endtask

  task automatic test_backpressure();
    bus_event(16'h1234, 8'hA5, 1'b0, 1'b1, 1'b1);
    bus_event(16'hBEEF, 8'h5A, 1'b1, 1'b0, 1'b1);
    bus_event(16'h00FF, 8'h01, 1'b0, 1'b1, 1'b1);
    start_halt();
    drain(1, -1);
    end_halt();
  endtask

  task automatic test_empty_halt();
    for (int k = 0; k < 2; k++) begin
      start_halt();
      for (int c = 0; c < 8; c++) begin
        @(negedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.dumping !== 1'b0) begin
          errors++;
          $display("FAIL empty_halt_%0d: valid=%b dumping=%b want 0/0", k, bus.out_valid, bus.dumping);
        end
      end
      end_halt();
    end
  endtask

  task automatic test_simultaneous();
    bus_event(16'h8000, 8'h55, 1'b1, 1'b1, 1'b1);
    bus_event(16'h4321, 8'h77, 1'b1, 1'b1, 1'b0);
    start_halt();
    drain(0, -1);
    end_halt();
  endtask

  task automatic test_reset_mid_dump();
    bus_event(16'hAAAA, 8'h11, 1'b0, 1'b1, 1'b1);
    bus_event(16'hBBBB, 8'h22, 1'b1, 1'b0, 1'b1);
    bus_event(16'hCCCC, 8'h33, 1'b0, 1'b1, 1'b1);
    start_halt();
    drain(0, 5);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.dumping !== 1'b0 || bus.out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_dump: valid=%b dumping=%b data=%h want 0/0/00",
               bus.out_valid, bus.dumping, bus.out_data);
    end
    @(negedge clk);
    bus.halt = 1'b0;
    reset = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    test_empty_halt();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_empty_halt();
    test_simultaneous();
    test_reset_mid_dump();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
